serial_add: RTL and testbench
=============================

Name: serial_add

Overview:
- Bit-serial multi-bit adder controller. Sits upstream of the team's full-adder stage and replaces a wide ripple chain with one full-adder slice reused over WIDTH cycles.
- Latches two WIDTH-bit operands and a carry-in on a start strobe. Each clock it feeds one bit pair plus the stored carry through the full-add function.
- Collects the sum bits into a result register and reports sum and carry-out with a done pulse.
- Intended for compact redstone builds where area matters more than latency.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request an addition; sampled on the rising edge of clk.
- a  input  WIDTH  operand A; sampled only on an accepted start.
- b  input  WIDTH  operand B; sampled only on an accepted start.
- cin  input  1  carry-in; sampled only on an accepted start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse; sum/cout are valid and new.
- sum  output  WIDTH  result of the last completed addition.
- cout  output  1  carry-out of the last completed addition.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low, and all flops clear immediately on assertion.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0, internal shift registers=0, carry flop=0, bit counter=0.
- FSM states: IDLE, RUN, DONE.
- Accepting start: start is accepted only in IDLE or DONE. An accepted start:
  - loads shA<=a, shB<=b, carry<=cin, cnt<=0;
  - moves state to RUN.
- RUN, each edge:
  - s = shA[0]^shB[0]^carry; c = majority(shA[0], shB[0], carry).
  - shA and shB shift right, with 0 shifted in at the MSB.
  - The partial-sum register shifts right with s inserted at the MSB; carry<=c; cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1:
    - sum<=the completed partial-sum register, including this edge's s in the MSB;
    - cout<=c; state<=DONE.
- Outputs by state:
  - busy = (state==RUN), combinational from state.
  - done = (state==DONE), so it is high for exactly one cycle.
- DONE: goes to IDLE next edge, unless start is high, in which case it goes to RUN with new operands (back-to-back).
- Latency: start accepted at edge k → done high in the cycle following edge k+WIDTH. Throughput is one result per WIDTH+1 cycles.
- start is ignored while busy=1; operand/cin changes during RUN have no effect.
- sum/cout change only on the completing edge. They hold the previous result throughout RUN and after DONE until the next completion.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1); unsigned, no saturation.
- Counter width: $clog2(WIDTH) bits, minimum 1. It never exceeds WIDTH-1.
- Reset mid-RUN aborts the operation: outputs return to reset values, with no done pulse.

Optional Feature:
- Macro: SERIAL_ADD_OVF_EN.
- Defined:
  - adds output ovf (1 bit, reset 0), updated with sum/cout on the completing edge;
  - ovf = carry into bit WIDTH-1 XOR cout, i.e. two's-complement signed overflow;
  - it holds like sum.
- Undefined: the ovf port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0, then release → busy=0, done=0, sum=0, cout=0. Assert rst_n=0 asynchronously mid-cycle → outputs clear without waiting for a clk edge.
- WIDTH=8, a=8'h5A, b=8'h33, cin=0, start for 1 cycle → busy for 8 cycles, done pulse for 1 cycle, sum=8'h8D, cout=0.
- a=8'hFF, b=8'h01, cin=0 → sum=8'h00, cout=1. Then a=0, b=0, cin=1 → sum=8'h01, cout=0.
- start re-pulsed with a=8'h11 during RUN → ignored, the original result completes on schedule. Then start held high through DONE with a=8'h01, b=8'h02 → next run begins with no IDLE cycle, sum=8'h03.
- rst_n pulsed low at cycle 4 of a run → no done, sum=0. A fresh start afterwards → correct result.
- With SERIAL_ADD_OVF_EN: a=8'h7F, b=8'h01 → sum=8'h80, ovf=1. Then a=8'hFF, b=8'h01 → ovf=0, cout=1.

Source files
------------

// File: rtl/serial_add.sv
// Bit-serial adder: one full-adder slice reused over WIDTH cycles, LSB first.
// Optional macro SERIAL_ADD_OVF_EN adds a registered signed-overflow output (ovf).
module serial_add #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-2:0] part;
  logic [WIDTH-1:0] part_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             s;
  logic             c;
  logic             accept;
  logic             last;

  // Handshake: start is a level sampled on each rising edge; it is taken
  // only when the engine is not in RUN (IDLE or DONE), otherwise dropped.
  assign accept = start && (state != RUN);
  assign last   = (state == RUN) && (cnt == LAST);

  // Full-add slice on the current LSB pair and the stored carry.
  assign s        = sh_a[0] ^ sh_b[0] ^ carry;
  assign c        = (sh_a[0] & sh_b[0]) | (sh_a[0] & carry) | (sh_b[0] & carry);
  // Only WIDTH-1 history bits are stored; the final bit goes straight to sum.
  assign part_nxt = {s, part};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_a  <= '0;
      sh_b  <= '0;
      part  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf   <= 1'b0;
`endif
    end else if (accept) begin
      sh_a  <= a;
      sh_b  <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      sh_a  <= {1'b0, sh_a[WIDTH-1:1]};
      sh_b  <= {1'b0, sh_b[WIDTH-1:1]};
      part  <= part_nxt[WIDTH-1:1];
      carry <= c;
      if (last) begin
        sum  <= part_nxt;
        cout <= c;
`ifdef SERIAL_ADD_OVF_EN
        // carry still holds the carry into the MSB on the completing edge.
        ovf  <= carry ^ c;
`endif
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_add.sv
// Self-checking bench for serial_add (WIDTH=8): vector table, hand-written
// corner sequences and an expected-result queue popped on each done pulse.
module tb_serial_add;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  serial_add #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // expected {ovf, cout, sum}
  logic [W+1:0] exp_q[$];
  logic [W:0]   last_res;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci);
    logic [W:0] r;
    logic       v;
    r = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    return {v, r};
  endfunction

  // scoreboard: every done pulse must match the oldest expected result
  always @(negedge clk) begin
    if (rst_n && done) begin
      logic [W+1:0] e;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sum_cout", {23'd0, cout, sum}, {23'd0, e[W:0]});
`ifdef SERIAL_ADD_OVF_EN
        check("ovf", {31'd0, ovf}, {31'd0, e[W+1]});
`endif
      end
    end
  end

  // drives one operation, checks busy length, hold of old result and done width
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    int           n;
    logic [W+1:0] e;
    e = model(x, y, ci);
    @(negedge clk);
    a = x; b = y; cin = ci; start = 1'b1;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    n = 0;
    while (!done && n < 40) begin
      if (busy) n++;
      if (n == W / 2) check("hold_during_run", {23'd0, cout, sum}, {23'd0, last_res});
      @(negedge clk);
    end
    check("busy_cycles", n, W);
    @(negedge clk);
    check("done_one_cycle", {31'd0, done}, 32'd0);
    last_res = e[W:0];
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 40) begin
      n++;
      @(negedge clk);
    end
    check(name, {31'd0, done}, 32'd1);
  endtask

  initial begin
    int done_seen;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    last_res = '0;

    vecs[0] = '{8'h5A, 8'h33, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0};
    vecs[2] = '{8'h00, 8'h00, 1'b1};
    vecs[3] = '{8'h7F, 8'h01, 1'b0};
    vecs[4] = '{8'hFF, 8'h01, 1'b0};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1};
    for (int i = 6; i < 8; i++)
      vecs[i] = '{W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
                  1'($urandom_range(0, 1))};

    // reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_sum_cout", {23'd0, cout, sum}, 32'd0);

    // vector table
    for (int i = 0; i < 8; i++) run_op(vecs[i].a, vecs[i].b, vecs[i].cin);

    // start re-pulsed during RUN is ignored; start held through DONE chains runs
    @(negedge clk);
    a = 8'h5A; b = 8'h33; cin = 1'b0; start = 1'b1;
    exp_q.push_back(model(8'h5A, 8'h33, 1'b0));
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'h11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 8'h01; b = 8'h02; cin = 1'b0; start = 1'b1;
    exp_q.push_back(model(8'h01, 8'h02, 1'b0));
    check("ignored_start_busy", {31'd0, busy}, 32'd1);
    wait_done("first_done");
    @(negedge clk);
    check("b2b_no_idle", {31'd0, busy}, 32'd1);
    start = 1'b0;
    wait_done("b2b_done");
    @(negedge clk);
    last_res = 9'h003;

    // asynchronous reset mid-run aborts without a done pulse
    @(negedge clk);
    a = 8'hC3; b = 8'h4D; cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_busy", {31'd0, busy}, 32'd0);
    check("async_sum_cout", {23'd0, cout, sum}, 32'd0);
    check("async_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_res = '0;
    done_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("no_done_after_abort", done_seen, 0);
    run_op(8'h5A, 8'h33, 1'b0);

    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
